// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared video types and screen geometry constants
package video_pkg;

    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int TEXT_COLS = 40;
    localparam int TEXT_ROWS = 24;
    localparam int CELL_PX   = 16;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic [1:0] {
        BLANK  = 2'd0,
        BORDER = 2'd1,
        TEXT   = 2'd2
    } region_e;

endpackage

// File: rtl/video_delay_line.sv
// rtl/video_delay_line.sv - fixed-depth shift register with a configurable reset value
module video_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/text_pixel_gen.sv
// rtl/text_pixel_gen.sv - 40x24 character-cell pixel generator with 3-cycle aligned output
module text_pixel_gen
    import video_pkg::*;
#(
    parameter logic [11:0] FG_RGB       = 12'hFFF,
    parameter logic [11:0] BG_RGB       = 12'h000,
    parameter logic [11:0] BORDER_RGB   = 12'h00F,
    parameter int          TOP_OFFSET   = 48,
    parameter int          FLASH_FRAMES = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       video_on,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] vram_addr,
    input  logic [7:0] vram_data,
    output logic [8:0] font_addr,
    input  logic [7:0] font_data,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b
);

    localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    // Stage 0: cell address and region classification
    logic [9:0] ty;
    logic [4:0] row;
    logic [5:0] col;
    region_e    region_d;
    logic [2:0] pixcol_d;
    logic [9:0] vram_addr_d, vram_addr_q;
    logic [2:0] glyph_row_d, glyph_row_q;
    logic       unused_bits;

    always_comb begin
        ty          = vcount - 10'(TOP_OFFSET);
        row         = ty[8:4];
        col         = hcount[9:4];
        glyph_row_d = ty[3:1];
        pixcol_d    = hcount[3:1];
        region_d    = TEXT;
        if (!video_on || hcount >= 10'(H_ACTIVE)) begin
            region_d = BLANK;
        end else if (vcount < 10'(TOP_OFFSET) ||
                     vcount >= 10'(TOP_OFFSET + TEXT_ROWS * CELL_PX)) begin
            region_d = BORDER;
        end
        // Outside the text area ty/row can be garbage; park the address at 0.
        vram_addr_d = '0;
        if (region_d == TEXT) begin
            vram_addr_d = {row, 5'b0} + {2'b0, row, 3'b0} + {4'b0, col};
        end
    end

    assign unused_bits = ^{ty[9], ty[0], hcount[0]};

    // Valid, region and pixel column ride alongside the fetch for two stages.
    logic [5:0] side_in, side_out;
    logic       valid_s2;
    region_e    region_s2;
    logic [2:0] pixcol_s2;

    assign side_in   = {1'b1, region_d, pixcol_d};
    assign valid_s2  = side_out[5];
    assign region_s2 = region_e'(side_out[4:3]);
    assign pixcol_s2 = side_out[2:0];

    video_delay_line #(
        .WIDTH    (6),
        .DEPTH    (2),
        .RESET_VAL(6'b0)
    ) u_side_dly (
        .clk  (clk),
        .n_rst(n_rst),
        .din  (side_in),
        .dout (side_out)
    );

    logic [1:0] sync_out;

    video_delay_line #(
        .WIDTH    (2),
        .DEPTH    (3),
        .RESET_VAL(2'b11)
    ) u_sync_dly (
        .clk  (clk),
        .n_rst(n_rst),
        .din  ({hsync_in, vsync_in}),
        .dout (sync_out)
    );

    assign hsync = sync_out[1];
    assign vsync = sync_out[0];

    // Stage 1: glyph row fetch
    logic [8:0] font_addr_d, font_addr_q;
    logic [1:0] attr_d, attr_q;

    always_comb begin
        font_addr_d = {vram_data[5:0], glyph_row_q};
        attr_d      = vram_data[7:6];
    end

    // Flash timebase counts vsync_in falling edges
    logic          vs_prev_d, vs_prev_q;
    logic [FW-1:0] flash_cnt_d, flash_cnt_q;
    logic          flash_phase_d, flash_phase_q;

    always_comb begin
        vs_prev_d     = vsync_in;
        flash_cnt_d   = flash_cnt_q;
        flash_phase_d = flash_phase_q;
        if (vs_prev_q && !vsync_in) begin
            if (flash_cnt_q == FW'(FLASH_FRAMES - 1)) begin
                flash_cnt_d   = '0;
                flash_phase_d = ~flash_phase_q;
            end else begin
                flash_cnt_d = flash_cnt_q + 1'b1;
            end
        end
    end

    // Stage 2: pixel select and colour
    logic    pix_bit;
    logic    pix_on;
    rgb444_t rgb_d, rgb_q;

    always_comb begin
        pix_bit = font_data[3'd7 - pixcol_s2];
        pix_on  = pix_bit ^ attr_q[1] ^ (attr_q[0] & flash_phase_q);
        rgb_d   = '0;
        if (valid_s2) begin
            case (region_s2)
                BORDER:  rgb_d = rgb444_t'(BORDER_RGB);
                TEXT:    rgb_d = pix_on ? rgb444_t'(FG_RGB) : rgb444_t'(BG_RGB);
                default: rgb_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vram_addr_q   <= '0;
            glyph_row_q   <= '0;
            font_addr_q   <= '0;
            attr_q        <= '0;
            vs_prev_q     <= 1'b1;
            flash_cnt_q   <= '0;
            flash_phase_q <= 1'b0;
            rgb_q         <= '0;
        end else begin
            vram_addr_q   <= vram_addr_d;
            glyph_row_q   <= glyph_row_d;
            font_addr_q   <= font_addr_d;
            attr_q        <= attr_d;
            vs_prev_q     <= vs_prev_d;
            flash_cnt_q   <= flash_cnt_d;
            flash_phase_q <= flash_phase_d;
            rgb_q         <= rgb_d;
        end
    end

    assign vram_addr = vram_addr_q;
    assign font_addr = font_addr_q;
    assign r         = rgb_q.r;
    assign g         = rgb_q.g;
    assign b         = rgb_q.b;

endmodule

// File: tb/tb_text_pixel_gen.sv
// tb/tb_text_pixel_gen.sv - directed-vector bench for text_pixel_gen
module tb_text_pixel_gen;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [9:0] hcount = '0;
    logic [9:0] vcount = '0;
    logic       video_on = 1'b0;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic [9:0] vram_addr;
    logic [7:0] vram_data;
    logic [8:0] font_addr;
    logic [7:0] font_data;
    logic       hsync, vsync;
    logic [3:0] r, g, b;

    logic [7:0] vram [1024];
    logic [7:0] font [512];

    int n_vec = 0;
    int n_err = 0;

    always #20 clk = ~clk;

    assign vram_data = vram[vram_addr];
    assign font_data = font[font_addr];

    text_pixel_gen dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .hcount   (hcount),
        .vcount   (vcount),
        .video_on (video_on),
        .hsync_in (hsync_in),
        .vsync_in (vsync_in),
        .vram_addr(vram_addr),
        .vram_data(vram_data),
        .font_addr(font_addr),
        .font_data(font_data),
        .hsync    (hsync),
        .vsync    (vsync),
        .r        (r),
        .g        (g),
        .b        (b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hold one pixel on the inputs and check each pipeline stage (negative = skip).
    task automatic run_px(input string tag, input logic [9:0] h, input logic [9:0] v,
                          input logic von, input int exp_addr, input int exp_font,
                          input logic [11:0] exp_rgb);
        hcount = h; vcount = v; video_on = von;
        @(posedge clk); @(negedge clk);
        if (exp_addr >= 0) check({tag, "_addr"}, 32'(vram_addr), exp_addr);
        @(posedge clk); @(negedge clk);
        if (exp_font >= 0) check({tag, "_font"}, 32'(font_addr), exp_font);
        @(posedge clk); @(negedge clk);
        check({tag, "_rgb"}, 32'({r, g, b}), 32'(exp_rgb));
    endtask

    task automatic pulse_vsync(input int n);
        for (int i = 0; i < n; i++) begin
            vsync_in = 1'b0;
            @(posedge clk); @(negedge clk);
            vsync_in = 1'b1;
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        check("rst_pulse_rgb", 32'({r, g, b}), 32'h0);
        @(negedge clk); @(negedge clk);
        n_rst = 1'b1;
    endtask

    int low_cnt;
    int first_low;

    initial begin
        for (int i = 0; i < 1024; i++) vram[i] = 8'h00;
        for (int i = 0; i < 512; i++) font[i] = 8'h00;
        vram[0]   = 8'h01;
        vram[1]   = 8'h81;
        vram[2]   = 8'h41;
        vram[959] = 8'h02;
        font[9'h008] = 8'b1000_0000;
        font[9'h017] = 8'b0000_0001;

        // Reset held low with toggling inputs
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            hcount   = 10'($urandom_range(0, 639));
            vcount   = 10'($urandom_range(0, 479));
            video_on = 1'b1;
            hsync_in = i[0];
            vsync_in = ~i[0];
            #1;
            check("rst_rgb", 32'({r, g, b}), 32'h0);
            check("rst_sync", 32'({hsync, vsync}), 32'h3);
        end
        check("rst_addr", 32'({vram_addr, font_addr}), 32'h0);

        // Release with a lit text pixel and hsync_in low already on the inputs
        hcount = 10'd0; vcount = 10'd48; video_on = 1'b1;
        hsync_in = 1'b0; vsync_in = 1'b1;
        n_rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rel1_rgb", 32'({r, g, b}), 32'h0);
        check("rel1_hs", 32'(hsync), 32'h1);
        @(posedge clk); @(negedge clk);
        check("rel2_rgb", 32'({r, g, b}), 32'h0);
        check("rel2_hs", 32'(hsync), 32'h1);
        @(posedge clk); @(negedge clk);
        check("rel3_rgb", 32'({r, g, b}), 32'hFFF);
        check("rel3_hs", 32'(hsync), 32'h0);
        hsync_in = 1'b1;
        repeat (3) begin @(posedge clk); @(negedge clk); end

        // Basic glyph lookup and pixel select
        run_px("lit",     10'd0,   10'd48,  1'b1, 0,   9'h008, 12'hFFF);
        run_px("unlit",   10'd2,   10'd48,  1'b1, 0,   9'h008, 12'h000);
        run_px("last",    10'd639, 10'd431, 1'b1, 959, 9'h017, 12'hFFF);
        run_px("bord_lo", 10'd0,   10'd432, 1'b1, 0,   -1,     12'h00F);
        run_px("bord_hi", 10'd100, 10'd10,  1'b1, 0,   -1,     12'h00F);
        run_px("voff",    10'd0,   10'd48,  1'b0, 0,   -1,     12'h000);
        run_px("hblank",  10'd640, 10'd48,  1'b1, 0,   -1,     12'h000);
        run_px("inv_lit", 10'd16,  10'd48,  1'b1, 1,   9'h008, 12'h000);
        run_px("inv_off", 10'd18,  10'd48,  1'b1, 1,   9'h008, 12'hFFF);

        // Flash: phase toggles on the 16th vsync falling edge
        run_px("fl_p0",   10'd32,  10'd48,  1'b1, 2,   9'h008, 12'hFFF);
        pulse_vsync(15);
        run_px("fl_15",   10'd32,  10'd48,  1'b1, -1,  -1,     12'hFFF);
        pulse_vsync(1);
        run_px("fl_16",   10'd32,  10'd48,  1'b1, -1,  -1,     12'h000);
        pulse_vsync(16);
        run_px("fl_32",   10'd32,  10'd48,  1'b1, -1,  -1,     12'hFFF);

        // Reset mid-count clears counter and phase
        pulse_vsync(16 + 5);
        run_px("fl_pre",  10'd32,  10'd48,  1'b1, -1,  -1,     12'h000);
        pulse_reset();
        run_px("fl_rst",  10'd32,  10'd48,  1'b1, -1,  -1,     12'hFFF);
        pulse_vsync(15);
        run_px("fl_r15",  10'd32,  10'd48,  1'b1, -1,  -1,     12'hFFF);
        pulse_vsync(1);
        run_px("fl_r16",  10'd32,  10'd48,  1'b1, -1,  -1,     12'h000);

        // hsync pulse of 96 cycles, delayed by 3
        low_cnt = 0;
        first_low = -1;
        hsync_in = 1'b0;
        for (int i = 1; i <= 110; i++) begin
            @(posedge clk); @(negedge clk);
            if (hsync == 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = i;
            end
            if (i == 96) hsync_in = 1'b1;
        end
        check("hs_width", 32'(low_cnt), 32'd96);
        check("hs_start", 32'(first_low), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
